// File: rtl/if_id_ex_pipe_regs.sv
// IF/ID and ID/EX pipeline registers for the 5-stage RV32I core, with stall-hold,
// bubble insertion, branch squash and saturating stall/flush event counters.
module if_id_ex_pipe_regs #(
    parameter int          XLEN      = 32,
    parameter int          CTRL_W    = 8,
    parameter int          CNT_W     = 16,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [XLEN-1:0]   pc_F,
    input  logic [31:0]       instr_F,
    input  logic              pc_write,
    input  logic              id_ex_flush,
    input  logic              branch_taken,
    input  logic [XLEN-1:0]   rd1_D,
    input  logic [XLEN-1:0]   rd2_D,
    input  logic [XLEN-1:0]   imm_D,
    input  logic [CTRL_W-1:0] ctrl_D,
    input  logic              reg_write_D,
    input  logic              is_load_D,
    output logic [XLEN-1:0]   pc_D,
    output logic [31:0]       instr_D,
    output logic              valid_D,
    output logic [4:0]        rs1D,
    output logic [4:0]        rs2D,
    output logic [4:0]        rdD,
    output logic [XLEN-1:0]   pc_E,
    output logic [XLEN-1:0]   rd1_E,
    output logic [XLEN-1:0]   rd2_E,
    output logic [XLEN-1:0]   imm_E,
    output logic [CTRL_W-1:0] ctrl_E,
    output logic [4:0]        rs1E,
    output logic [4:0]        rs2E,
    output logic [4:0]        rdE,
    output logic              reg_write_E,
    output logic              is_load_E,
    output logic              valid_E,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic [XLEN-1:0]   r_pc_D;
    logic [31:0]       r_instr_D;
    logic              r_valid_D;
    logic [XLEN-1:0]   r_pc_E, r_rd1_E, r_rd2_E, r_imm_E;
    logic [CTRL_W-1:0] r_ctrl_E;
    logic [4:0]        r_rs1E, r_rs2E, r_rdE;
    logic              r_reg_write_E, r_is_load_E, r_valid_E;
    logic [CNT_W-1:0]  r_stall_cnt, r_flush_cnt;

    logic [4:0]        w_rs1D, w_rs2D, w_rdD;
    logic              w_bubble_E;
    logic              w_stall;

    // Specifiers are pure decode of registered state, so the hazard unit sees no input-to-output path.
    assign w_rs1D     = r_valid_D ? r_instr_D[19:15] : 5'd0;
    assign w_rs2D     = r_valid_D ? r_instr_D[24:20] : 5'd0;
    assign w_rdD      = r_valid_D ? r_instr_D[11:7]  : 5'd0;
    assign w_bubble_E = branch_taken | id_ex_flush;
    assign w_stall    = ~pc_write & ~branch_taken;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc_D        <= '0;
            r_instr_D     <= NOP_INSTR;
            r_valid_D     <= 1'b0;
            r_pc_E        <= '0;
            r_rd1_E       <= '0;
            r_rd2_E       <= '0;
            r_imm_E       <= '0;
            r_ctrl_E      <= '0;
            r_rs1E        <= '0;
            r_rs2E        <= '0;
            r_rdE         <= '0;
            r_reg_write_E <= 1'b0;
            r_is_load_E   <= 1'b0;
            r_valid_E     <= 1'b0;
            r_stall_cnt   <= '0;
            r_flush_cnt   <= '0;
        end else begin
            // Squash outranks the stall hold: a redirected fetch must not survive in ID.
            if (branch_taken) begin
                r_instr_D <= NOP_INSTR;
                r_pc_D    <= '0;
                r_valid_D <= 1'b0;
            end else if (pc_write) begin
                r_instr_D <= instr_F;
                r_pc_D    <= pc_F;
                r_valid_D <= 1'b1;
            end

            if (w_bubble_E) begin
                r_pc_E        <= '0;
                r_rd1_E       <= '0;
                r_rd2_E       <= '0;
                r_imm_E       <= '0;
                r_ctrl_E      <= '0;
                r_rs1E        <= '0;
                r_rs2E        <= '0;
                r_rdE         <= '0;
                r_reg_write_E <= 1'b0;
                r_is_load_E   <= 1'b0;
                r_valid_E     <= 1'b0;
            end else begin
                r_pc_E        <= r_pc_D;
                r_rd1_E       <= rd1_D;
                r_rd2_E       <= rd2_D;
                r_imm_E       <= imm_D;
                r_ctrl_E      <= ctrl_D;
                r_rs1E        <= w_rs1D;
                r_rs2E        <= w_rs2D;
                r_rdE         <= w_rdD;
                r_reg_write_E <= reg_write_D & r_valid_D;
                r_is_load_E   <= is_load_D & r_valid_D;
                r_valid_E     <= r_valid_D;
            end

            if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
            if (branch_taken && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign pc_D        = r_pc_D;
    assign instr_D     = r_instr_D;
    assign valid_D     = r_valid_D;
    assign rs1D        = w_rs1D;
    assign rs2D        = w_rs2D;
    assign rdD         = w_rdD;
    assign pc_E        = r_pc_E;
    assign rd1_E       = r_rd1_E;
    assign rd2_E       = r_rd2_E;
    assign imm_E       = r_imm_E;
    assign ctrl_E      = r_ctrl_E;
    assign rs1E        = r_rs1E;
    assign rs2E        = r_rs2E;
    assign rdE         = r_rdE;
    assign reg_write_E = r_reg_write_E;
    assign is_load_E   = r_is_load_E;
    assign valid_E     = r_valid_E;
    assign stall_cnt   = r_stall_cnt;
    assign flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_if_id_ex_pipe_regs.sv
// Bench for if_id_ex_pipe_regs: directed vector table, counter saturation on a
// narrow-counter instance, then randomized traffic against a stage-record model.
module tb_if_id_ex_pipe_regs;

    localparam logic [31:0] NOP  = 32'h00000013;
    localparam logic [31:0] I0   = 32'h00500093; // addi x1,x0,5
    localparam logic [31:0] LW   = 32'h0000A283; // lw x5,0(x1)
    localparam logic [31:0] ADD  = 32'h00128333; // add x6,x5,x1

    logic        clk = 1'b0;
    logic        rst_n, pc_write, id_ex_flush, branch_taken, reg_write_D, is_load_D;
    logic [31:0] pc_F, instr_F, rd1_D, rd2_D, imm_D;
    logic [7:0]  ctrl_D;

    logic [31:0] pc_D, instr_D, pc_E, rd1_E, rd2_E, imm_E;
    logic        valid_D, reg_write_E, is_load_E, valid_E;
    logic [4:0]  rs1D, rs2D, rdD, rs1E, rs2E, rdE;
    logic [7:0]  ctrl_E;
    logic [15:0] stall_cnt, flush_cnt;

    logic [31:0] s_pc_D, s_instr_D, s_pc_E, s_rd1_E, s_rd2_E, s_imm_E;
    logic        s_valid_D, s_reg_write_E, s_is_load_E, s_valid_E;
    logic [4:0]  s_rs1D, s_rs2D, s_rdD, s_rs1E, s_rs2E, s_rdE;
    logic [7:0]  s_ctrl_E;
    logic [3:0]  s_stall_cnt, s_flush_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    if_id_ex_pipe_regs u_dut (
        .clk(clk), .rst_n(rst_n), .pc_F(pc_F), .instr_F(instr_F),
        .pc_write(pc_write), .id_ex_flush(id_ex_flush), .branch_taken(branch_taken),
        .rd1_D(rd1_D), .rd2_D(rd2_D), .imm_D(imm_D), .ctrl_D(ctrl_D),
        .reg_write_D(reg_write_D), .is_load_D(is_load_D),
        .pc_D(pc_D), .instr_D(instr_D), .valid_D(valid_D),
        .rs1D(rs1D), .rs2D(rs2D), .rdD(rdD),
        .pc_E(pc_E), .rd1_E(rd1_E), .rd2_E(rd2_E), .imm_E(imm_E), .ctrl_E(ctrl_E),
        .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
        .reg_write_E(reg_write_E), .is_load_E(is_load_E), .valid_E(valid_E),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    if_id_ex_pipe_regs #(.CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .pc_F(pc_F), .instr_F(instr_F),
        .pc_write(pc_write), .id_ex_flush(id_ex_flush), .branch_taken(branch_taken),
        .rd1_D(rd1_D), .rd2_D(rd2_D), .imm_D(imm_D), .ctrl_D(ctrl_D),
        .reg_write_D(reg_write_D), .is_load_D(is_load_D),
        .pc_D(s_pc_D), .instr_D(s_instr_D), .valid_D(s_valid_D),
        .rs1D(s_rs1D), .rs2D(s_rs2D), .rdD(s_rdD),
        .pc_E(s_pc_E), .rd1_E(s_rd1_E), .rd2_E(s_rd2_E), .imm_E(s_imm_E), .ctrl_E(s_ctrl_E),
        .rs1E(s_rs1E), .rs2E(s_rs2E), .rdE(s_rdE),
        .reg_write_E(s_reg_write_E), .is_load_E(s_is_load_E), .valid_E(s_valid_E),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    // Reference model: one record per stage plus unbounded event counts.
    typedef struct {
        logic [31:0] instr, pc;
        logic        valid;
    } d_rec_t;
    typedef struct {
        logic [31:0] pc, rd1, rd2, imm;
        logic [7:0]  ctrl;
        logic [4:0]  rs1, rs2, rd;
        logic        rw, ld, valid;
    } e_rec_t;

    d_rec_t m_d;
    e_rec_t m_e;
    int     m_stall, m_flush;

    function automatic logic [4:0] fld(input d_rec_t d, input int lsb);
        logic [31:0] w;
        w = d.instr >> lsb;
        return d.valid ? w[4:0] : 5'd0;
    endfunction

    function automatic int sat(input int v, input int bits);
        int top;
        top = (1 << bits) - 1;
        return (v > top) ? top : v;
    endfunction

    task automatic model_step();
        e_rec_t ne;
        if (!rst_n) begin
            m_d     = '{instr: NOP, pc: 32'd0, valid: 1'b0};
            m_e     = '{default: '0};
            m_stall = 0;
            m_flush = 0;
        end else begin
            ne = '{default: '0};
            if (!(branch_taken || id_ex_flush)) begin
                ne.pc    = m_d.pc;
                ne.rd1   = rd1_D;
                ne.rd2   = rd2_D;
                ne.imm   = imm_D;
                ne.ctrl  = ctrl_D;
                ne.rs1   = fld(m_d, 15);
                ne.rs2   = fld(m_d, 20);
                ne.rd    = fld(m_d, 7);
                ne.rw    = reg_write_D && m_d.valid;
                ne.ld    = is_load_D && m_d.valid;
                ne.valid = m_d.valid;
            end
            m_e = ne;
            if (branch_taken)  m_d = '{instr: NOP, pc: 32'd0, valid: 1'b0};
            else if (pc_write) m_d = '{instr: instr_F, pc: pc_F, valid: 1'b1};
            if (!pc_write && !branch_taken) m_stall++;
            if (branch_taken) m_flush++;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs were driven after the previous edge; sample #1 past this edge.
    task automatic cycle();
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic drive(input logic r, input logic pw, input logic fl, input logic br,
                         input logic ld, input logic [31:0] pc, input logic [31:0] ins);
        rst_n        = r;
        pc_write     = pw;
        id_ex_flush  = fl;
        branch_taken = br;
        is_load_D    = ld;
        reg_write_D  = 1'b1;
        pc_F         = pc;
        instr_F      = ins;
        rd1_D        = $urandom;
        rd2_D        = $urandom;
        imm_D        = $urandom;
        ctrl_D       = 8'($urandom);
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".pc_D"},        pc_D,        m_d.pc);
        chk({tag, ".instr_D"},     instr_D,     m_d.instr);
        chk({tag, ".valid_D"},     32'(valid_D),     32'(m_d.valid));
        chk({tag, ".rs1D"},        32'(rs1D),        32'(fld(m_d, 15)));
        chk({tag, ".rs2D"},        32'(rs2D),        32'(fld(m_d, 20)));
        chk({tag, ".rdD"},         32'(rdD),         32'(fld(m_d, 7)));
        chk({tag, ".pc_E"},        pc_E,        m_e.pc);
        chk({tag, ".rd1_E"},       rd1_E,       m_e.rd1);
        chk({tag, ".rd2_E"},       rd2_E,       m_e.rd2);
        chk({tag, ".imm_E"},       imm_E,       m_e.imm);
        chk({tag, ".ctrl_E"},      32'(ctrl_E),      32'(m_e.ctrl));
        chk({tag, ".rs1E"},        32'(rs1E),        32'(m_e.rs1));
        chk({tag, ".rs2E"},        32'(rs2E),        32'(m_e.rs2));
        chk({tag, ".rdE"},         32'(rdE),         32'(m_e.rd));
        chk({tag, ".reg_write_E"}, 32'(reg_write_E), 32'(m_e.rw));
        chk({tag, ".is_load_E"},   32'(is_load_E),   32'(m_e.ld));
        chk({tag, ".valid_E"},     32'(valid_E),     32'(m_e.valid));
        chk({tag, ".stall_cnt"},   32'(stall_cnt),   32'(sat(m_stall, 16)));
        chk({tag, ".flush_cnt"},   32'(flush_cnt),   32'(sat(m_flush, 16)));
        chk({tag, ".sat_stall"},   32'(s_stall_cnt), 32'(sat(m_stall, 4)));
        chk({tag, ".sat_flush"},   32'(s_flush_cnt), 32'(sat(m_flush, 4)));
    endtask

    typedef struct {
        logic        rst_n, pw, fl, br, ld;
        logic [31:0] pc_F, instr_F;
        logic [31:0] e_instr_D, e_pc_D;
        logic        e_vD;
        logic [4:0]  e_rdD;
        logic [31:0] e_pc_E;
        logic [4:0]  e_rdE, e_rs1E;
        logic        e_vE, e_ldE, e_rwE;
        logic [15:0] e_stall, e_flush;
    } vec_t;

    vec_t tbl[12];

    initial begin
        // rst pw fl br ld  pc_F  instr_F | instr_D pc_D vD rdD | pc_E rdE rs1E vE ldE rwE | stall flush
        tbl[0]  = '{0, 1, 0, 0, 0,  0, I0,   NOP,  0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0};
        tbl[1]  = '{0, 1, 0, 0, 0,  0, I0,   NOP,  0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0};
        tbl[2]  = '{1, 1, 0, 0, 0,  0, I0,   I0,   0, 1, 1,  0, 0, 0, 0, 0, 0,  0, 0};
        tbl[3]  = '{1, 1, 0, 0, 0,  4, LW,   LW,   4, 1, 5,  0, 1, 0, 1, 0, 1,  0, 0};
        tbl[4]  = '{1, 1, 0, 0, 1,  8, ADD,  ADD,  8, 1, 6,  4, 5, 1, 1, 1, 1,  0, 0};
        tbl[5]  = '{1, 0, 1, 0, 0, 12, I0,   ADD,  8, 1, 6,  0, 0, 0, 0, 0, 0,  1, 0};
        tbl[6]  = '{1, 1, 0, 0, 0, 12, I0,   I0,  12, 1, 1,  8, 6, 5, 1, 0, 1,  1, 0};
        tbl[7]  = '{1, 0, 1, 1, 1, 16, LW,   NOP,  0, 0, 0,  0, 0, 0, 0, 0, 0,  1, 1};
        tbl[8]  = '{1, 1, 0, 0, 1, 20, ADD,  ADD, 20, 1, 6,  0, 0, 0, 0, 0, 0,  1, 1};
        tbl[9]  = '{1, 0, 0, 0, 0, 24, I0,   ADD, 20, 1, 6, 20, 6, 5, 1, 0, 1,  2, 1};
        tbl[10] = '{0, 0, 0, 0, 0, 24, I0,   NOP,  0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0};
        tbl[11] = '{1, 1, 0, 0, 1, 28, LW,   LW,  28, 1, 5,  0, 0, 0, 0, 0, 0,  0, 0};

        m_d = '{instr: NOP, pc: 32'd0, valid: 1'b0};
        m_e = '{default: '0};
        m_stall = 0;
        m_flush = 0;

        // Directed table: reset, normal flow, load-use, squash, reset mid-stall.
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].rst_n, tbl[i].pw, tbl[i].fl, tbl[i].br, tbl[i].ld,
                  tbl[i].pc_F, tbl[i].instr_F);
            cycle();
            chk($sformatf("v%0d.instr_D", i),     instr_D,           tbl[i].e_instr_D);
            chk($sformatf("v%0d.pc_D", i),        pc_D,              tbl[i].e_pc_D);
            chk($sformatf("v%0d.valid_D", i),     32'(valid_D),      32'(tbl[i].e_vD));
            chk($sformatf("v%0d.rdD", i),         32'(rdD),          32'(tbl[i].e_rdD));
            chk($sformatf("v%0d.pc_E", i),        pc_E,              tbl[i].e_pc_E);
            chk($sformatf("v%0d.rdE", i),         32'(rdE),          32'(tbl[i].e_rdE));
            chk($sformatf("v%0d.rs1E", i),        32'(rs1E),         32'(tbl[i].e_rs1E));
            chk($sformatf("v%0d.valid_E", i),     32'(valid_E),      32'(tbl[i].e_vE));
            chk($sformatf("v%0d.is_load_E", i),   32'(is_load_E),    32'(tbl[i].e_ldE));
            chk($sformatf("v%0d.reg_write_E", i), 32'(reg_write_E),  32'(tbl[i].e_rwE));
            chk($sformatf("v%0d.stall_cnt", i),   32'(stall_cnt),    32'(tbl[i].e_stall));
            chk($sformatf("v%0d.flush_cnt", i),   32'(flush_cnt),    32'(tbl[i].e_flush));
        end

        // Counter saturation: 20 stalled cycles, then 20 squashed cycles.
        drive(0, 1, 0, 0, 0, 0, I0);
        cycle();
        for (int i = 0; i < 20; i++) begin
            drive(1, 0, 0, 0, 0, 32'(4 * i), I0);
            cycle();
        end
        chk("sat.stall_w16", 32'(stall_cnt),   32'd20);
        chk("sat.stall_w4",  32'(s_stall_cnt), 32'd15);
        chk("sat.flush_w4",  32'(s_flush_cnt), 32'd0);
        for (int i = 0; i < 20; i++) begin
            drive(1, 0, 1, 1, 0, 32'(4 * i), LW);
            cycle();
        end
        chk("sat.flush_w16", 32'(flush_cnt),   32'd20);
        chk("sat.flush_w4b", 32'(s_flush_cnt), 32'd15);
        chk("sat.stall_w4b", 32'(s_stall_cnt), 32'd15);
        chk("sat.stall_w16b", 32'(stall_cnt),  32'd20);

        // Randomized traffic against the model.
        drive(0, 1, 0, 0, 0, 0, NOP);
        cycle();
        check_model("rst");
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 99) >= 3),
                  ($urandom_range(0, 99) >= 25),
                  ($urandom_range(0, 99) < 20),
                  ($urandom_range(0, 99) < 10),
                  1'($urandom),
                  $urandom & 32'hFFFF_FFFC,
                  $urandom);
            reg_write_D = 1'($urandom);
            cycle();
            check_model($sformatf("r%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
